// File: rtl/synth_param_bank_if.sv
// Avalon-MM slave bus bundle for synth_param_bank.
//   address    : word address, ADDR_W bits (master -> slave)
//   chipselect : slave select (master -> slave)
//   write_n    : active-low write strobe (master -> slave)
//   writedata  : 32-bit write data (master -> slave)
//   readdata   : 32-bit read data, zero wait states (slave -> master)
interface synth_param_bank_if #(
    parameter int unsigned ADDR_W = 3
) ();
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/synth_param_bank.sv
// Multi-channel synthesizer parameter bank. Software writes shadow registers,
// requests a commit, and all shadows move to the targets together on the next
// sample tick. Each channel output then slews toward its target by a
// programmable step per sample tick.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : Avalon-MM slave (readdata combinational from registers)
//   sample_tick  : one-clk pulse per audio sample
//   out_port     : slewed outputs, channel i at [i*DATA_W +: DATA_W]
//   busy         : commit pending or any channel still ramping
module synth_param_bank #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ADDR_W     = 3,
    parameter logic [31:0] RESET_VAL  = 32'h0,
    parameter logic [31:0] SLEW_RESET = 32'h0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    synth_param_bank_if.slave        bus,
    input  logic                     sample_tick,
    output logic [NUM_CH*DATA_W-1:0] out_port,
    output logic                     busy
);
    localparam logic [ADDR_W-1:0] A_COMMIT = ADDR_W'(NUM_CH);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(NUM_CH + 1);
    localparam logic [ADDR_W-1:0] A_SLEW   = ADDR_W'(NUM_CH + 2);
    localparam logic [DATA_W-1:0] RST_V    = DATA_W'(RESET_VAL);
    localparam logic [DATA_W-1:0] RST_SLEW = DATA_W'(SLEW_RESET);

    logic [DATA_W-1:0] shadow_q [NUM_CH];
    logic [DATA_W-1:0] shadow_d [NUM_CH];
    logic [DATA_W-1:0] target_q [NUM_CH];
    logic [DATA_W-1:0] target_d [NUM_CH];
    logic [DATA_W-1:0] out_q    [NUM_CH];
    logic [DATA_W-1:0] out_d    [NUM_CH];
    logic [DATA_W-1:0] slewed_c [NUM_CH];
    logic [DATA_W-1:0] slew_q, slew_d;
    logic              pending_q, pending_d;
    logic [NUM_CH-1:0] status_c;
    logic              wr_c;
    logic              load_c;
    logic              unused_wdata_c;

    assign wr_c           = bus.chipselect & ~bus.write_n;
    assign load_c         = sample_tick & pending_q;
    assign unused_wdata_c = ^bus.writedata;

    // Per-channel slew step and ramp status, all from pre-edge register values.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic              up_c;
        logic [DATA_W:0]   diff_c;

        assign up_c   = target_q[g] > out_q[g];
        assign diff_c = up_c ? ({1'b0, target_q[g]} - {1'b0, out_q[g]})
                             : ({1'b0, out_q[g]} - {1'b0, target_q[g]});
        // A step no smaller than the remaining distance lands exactly on target.
        assign slewed_c[g] = ((slew_q == '0) || (diff_c <= {1'b0, slew_q})) ? target_q[g]
                           : (up_c ? (out_q[g] + slew_q) : (out_q[g] - slew_q));
        assign status_c[g] = out_q[g] != target_q[g];
        assign out_port[g*DATA_W +: DATA_W] = out_q[g];
    end

    assign busy = pending_q | (|status_c);

    // Next-state: register writes, commit handshake, tick-driven load and slew.
    always_comb begin
        shadow_d  = shadow_q;
        target_d  = target_q;
        out_d     = out_q;
        slew_d    = slew_q;
        pending_d = pending_q;

        if (wr_c) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.address == ADDR_W'(i)) begin
                    shadow_d[i] = bus.writedata[DATA_W-1:0];
                end
            end
            if (bus.address == A_SLEW) begin
                slew_d = bus.writedata[DATA_W-1:0];
            end
        end

        // A load consumes the tick; a commit write in that same cycle is redundant.
        if (load_c) begin
            target_d  = shadow_q;
            pending_d = 1'b0;
        end else if (wr_c && (bus.address == A_COMMIT) && bus.writedata[0]) begin
            pending_d = 1'b1;
        end

        if (sample_tick) begin
            out_d = slewed_c;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= RST_V;
                target_q[i] <= RST_V;
                out_q[i]    <= RST_V;
            end
            slew_q    <= RST_SLEW;
            pending_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            target_q  <= target_d;
            out_q     <= out_d;
            slew_q    <= slew_d;
            pending_q <= pending_d;
        end
    end

    // Zero-wait-state read mux over current register state.
    always_comb begin
        bus.readdata = 32'h0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.address == ADDR_W'(i)) begin
                bus.readdata = 32'(shadow_q[i]);
            end
        end
        if (bus.address == A_COMMIT) begin
            bus.readdata = 32'(pending_q);
        end
        if (bus.address == A_STATUS) begin
            bus.readdata = 32'(status_c);
        end
        if (bus.address == A_SLEW) begin
            bus.readdata = 32'(slew_q);
        end
    end
endmodule

// File: tb/tb_synth_param_bank.sv
module tb_synth_param_bank;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 3;
    localparam logic [ADDR_W-1:0] A_COMMIT = 3'd4;
    localparam logic [ADDR_W-1:0] A_STATUS = 3'd5;
    localparam logic [ADDR_W-1:0] A_SLEW   = 3'd6;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic                     clk;
    logic                     reset_n;
    logic                     sample_tick;
    logic [NUM_CH*DATA_W-1:0] out_port;
    logic                     busy;
    int                       errors;
    int                       checks;
    exp_t                     exp_q[$];

    synth_param_bank_if #(.ADDR_W(ADDR_W)) bus ();

    synth_param_bank #(
        .NUM_CH    (NUM_CH),
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .RESET_VAL (32'h10),
        .SLEW_RESET(32'h0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus.slave),
        .sample_tick(sample_tick),
        .out_port   (out_port),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: observed=%h expected=<none>", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    // One-cycle write, optionally coincident with a sample tick.
    task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic tick);
        @(negedge clk);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        sample_tick    = tick;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        sample_tick    = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic exp_rd(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] v);
        push(tag, v);
        @(negedge clk);
        bus.address    = a;
        bus.chipselect = 1'b1;
        #1;
        check(bus.readdata);
        bus.chipselect = 1'b0;
    endtask

    task automatic exp_port(input string tag, input logic [31:0] v);
        push(tag, v);
        check(32'(out_port));
    endtask

    task automatic exp_busy(input string tag, input logic v);
        push(tag, 32'(v));
        check(32'(busy));
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        reset_n        = 1'b0;
        sample_tick    = 1'b0;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'h0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset state and readback
        exp_port("rst_out", 32'h10101010);
        exp_busy("rst_busy", 1'b0);
        for (int i = 0; i < NUM_CH; i++) exp_rd("rst_shadow", ADDR_W'(i), 32'h10);
        exp_rd("rst_pending", A_COMMIT, 32'h0);
        exp_rd("rst_slew", A_SLEW, 32'h0);
        wr(3'd2, 32'hFFFF_FFAB, 1'b0);
        exp_rd("shadow2_rb", 3'd2, 32'hAB);
        exp_port("shadow_no_out", 32'h10101010);

        // Atomic commit with slew = 0
        wr(3'd0, 32'h11, 1'b0);
        wr(3'd1, 32'h22, 1'b0);
        wr(3'd2, 32'h33, 1'b0);
        wr(3'd3, 32'h44, 1'b0);
        wr(A_COMMIT, 32'h2, 1'b0);
        exp_rd("commit_bit0_0", A_COMMIT, 32'h0);
        wr(A_COMMIT, 32'h1, 1'b0);
        exp_rd("pending_set", A_COMMIT, 32'h1);
        exp_busy("busy_pending", 1'b1);
        exp_port("no_tick_hold", 32'h10101010);
        tick();
        exp_rd("pending_clr", A_COMMIT, 32'h0);
        exp_port("load_tick_out", 32'h10101010);
        exp_rd("status_after_load", A_STATUS, 32'hF);
        tick();
        exp_port("commit_out", 32'h44332211);
        exp_busy("commit_busy", 1'b0);

        // Upward ramp on channel 0
        wr(3'd0, 32'h00, 1'b0);
        wr(A_COMMIT, 32'h1, 1'b0);
        tick();
        tick();
        exp_port("ch0_zero", 32'h44332200);
        wr(A_SLEW, 32'h10, 1'b0);
        exp_rd("slew_rb", A_SLEW, 32'h10);
        wr(3'd0, 32'h35, 1'b0);
        wr(A_COMMIT, 32'h1, 1'b0);
        tick();
        exp_port("ramp_load", 32'h44332200);
        exp_rd("ramp_status", A_STATUS, 32'h1);
        tick();
        exp_port("ramp_10", 32'h44332210);
        tick();
        exp_port("ramp_20", 32'h44332220);
        tick();
        exp_port("ramp_30", 32'h44332230);
        exp_busy("ramp_busy", 1'b1);
        tick();
        exp_port("ramp_35", 32'h44332235);
        exp_rd("ramp_status_done", A_STATUS, 32'h0);
        exp_busy("ramp_idle", 1'b0);

        // Downward ramp, no overshoot
        wr(3'd0, 32'h30, 1'b0);
        wr(A_COMMIT, 32'h1, 1'b0);
        tick();
        tick();
        exp_port("down_30", 32'h44332230);
        wr(A_SLEW, 32'h0, 1'b0);
        wr(3'd0, 32'hFF, 1'b0);
        wr(A_COMMIT, 32'h1, 1'b0);
        tick();
        tick();
        exp_port("up_ff", 32'h443322FF);
        wr(A_SLEW, 32'h80, 1'b0);
        wr(3'd0, 32'h00, 1'b0);
        wr(A_COMMIT, 32'h1, 1'b0);
        tick();
        tick();
        exp_port("down_7f", 32'h4433227F);
        tick();
        exp_port("down_00", 32'h44332200);

        // Simultaneous events
        wr(A_SLEW, 32'h0, 1'b0);
        wr(3'd1, 32'h55, 1'b0);
        wr(A_COMMIT, 32'h1, 1'b1);
        exp_rd("commit_with_tick", A_COMMIT, 32'h1);
        exp_port("no_load_same_tick", 32'h44332200);
        wr(3'd1, 32'h66, 1'b1);
        exp_rd("pending_after_load", A_COMMIT, 32'h0);
        exp_rd("shadow_new_kept", 3'd1, 32'h66);
        tick();
        exp_port("target_old_shadow", 32'h44335500);
        wr(A_COMMIT, 32'h1, 1'b0);
        tick();
        tick();
        exp_port("target_new_shadow", 32'h44336600);

        // Asynchronous reset mid-ramp with a commit pending
        wr(A_SLEW, 32'h1, 1'b0);
        wr(3'd3, 32'h00, 1'b0);
        wr(A_COMMIT, 32'h1, 1'b0);
        tick();
        tick();
        exp_port("pre_reset_ramp", 32'h43336600);
        wr(A_COMMIT, 32'h1, 1'b0);
        @(negedge clk);
        bus.address = A_COMMIT;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        exp_port("async_rst_out", 32'h10101010);
        exp_busy("async_rst_busy", 1'b0);
        push("async_rst_pending", 32'h0);
        check(bus.readdata);
        @(negedge clk);
        reset_n = 1'b1;
        exp_rd("post_rst_slew", A_SLEW, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
